// File: rtl/via6522.sv
// via6522: synthesizable subset of the MOS 6522 VIA for the 0xB8xx slot.
// Two 8-bit ports with direction registers, Timer 1 (one-shot/free-run),
// Timer 2 (one-shot), IFR/IER interrupt logic and an active-low IRQ.
// Optional feature macro: VIA_PB7_EN (T1 drives PB7 when ACR7=1).
module via6522 #(
  parameter logic [15:0] T_RESET = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       rnw,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic [7:0] pa_oe,
  input  logic [7:0] pb_in,
  output logic [7:0] pb_out,
  output logic [7:0] pb_oe,
  output logic       irq_n
);

  logic [7:0]  orb, ora, ddrb, ddra, acr, pcr;
  logic [6:0]  ifr, ier;
  logic [6:0]  ifr_set, ifr_clr;
  logic [15:0] t1_latch, t1_cnt, t2_cnt;
  logic [7:0]  t2_latch_l;
  logic        t1_armed, t1_hold, t1_fire, t1_load;
  logic        t2_armed, t2_fire, t2_load;
  logic        wr, rd, irq;
  logic        pb7_flop, pb7_active;
  logic [7:0]  irb;

  assign wr      = cs & ~rnw;
  assign rd      = cs & rnw;
  assign t1_load = wr && (addr == 4'h5);
  assign t2_load = wr && (addr == 4'h9);

  // A free-run reload holds the counter for one extra cycle so that the
  // period is latch+2, matching the original chip's 0 -> FFFF -> latch step.
  assign t1_fire = t1_armed && (t1_cnt == 16'h0000) && !t1_hold;
  assign t2_fire = t2_armed && (t2_cnt == 16'h0000);

  // Plain storage registers: ports, direction registers, ACR and PCR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      orb  <= 8'h00;
      ora  <= 8'h00;
      ddrb <= 8'h00;
      ddra <= 8'h00;
      acr  <= 8'h00;
      pcr  <= 8'h00;
    end else if (wr) begin
      case (addr)
        4'h0:        orb  <= din;
        4'h1, 4'hF:  ora  <= din;
        4'h2:        ddrb <= din;
        4'h3:        ddra <= din;
        4'hB:        acr  <= din;
        4'hC:        pcr  <= din;
        default:     ;
      endcase
    end
  end

  // Timer 1 latch: low byte from regs 4/6, high byte from regs 5/7.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t1_latch <= 16'h0000;
    end else if (wr) begin
      if (addr == 4'h4 || addr == 4'h6) t1_latch[7:0]  <= din;
      if (addr == 4'h5 || addr == 4'h7) t1_latch[15:8] <= din;
    end
  end

  // Timer 1 counter: a T1C-H write beats a free-run reload on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t1_cnt   <= T_RESET;
      t1_armed <= 1'b0;
      t1_hold  <= 1'b0;
    end else if (t1_load) begin
      t1_cnt   <= {din, t1_latch[7:0]};
      t1_armed <= 1'b1;
      t1_hold  <= 1'b0;
    end else if (t1_hold) begin
      t1_hold  <= 1'b0;
    end else if ((t1_cnt == 16'h0000) && acr[6]) begin
      t1_cnt   <= t1_latch;
      t1_hold  <= 1'b1;
    end else begin
      t1_cnt   <= t1_cnt - 16'd1;
      if (t1_fire) t1_armed <= 1'b0;
    end
  end

  // Timer 2: one-shot only, fires once per T2C-H write then free-wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t2_latch_l <= 8'h00;
      t2_cnt     <= T_RESET;
      t2_armed   <= 1'b0;
    end else begin
      if (wr && addr == 4'h8) t2_latch_l <= din;
      if (t2_load) begin
        t2_cnt   <= {din, t2_latch_l};
        t2_armed <= 1'b1;
      end else begin
        t2_cnt   <= t2_cnt - 16'd1;
        if (t2_fire) t2_armed <= 1'b0;
      end
    end
  end

  // Collect the interrupt-flag set and clear requests for this edge.
  always_comb begin
    ifr_set = {t1_fire, t2_fire, 5'b00000};
    ifr_clr = 7'h00;
    if (wr && addr == 4'hD) ifr_clr = din[6:0];
    if ((rd && addr == 4'h4) || (wr && (addr == 4'h5 || addr == 4'h7))) ifr_clr[6] = 1'b1;
    if ((rd && addr == 4'h8) || t2_load) ifr_clr[5] = 1'b1;
  end

  // Interrupt flags (set wins over clear) and the interrupt enable mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifr <= 7'h00;
      ier <= 7'h00;
    end else begin
      ifr <= (ifr & ~ifr_clr) | ifr_set;
      if (wr && addr == 4'hE) begin
        if (din[7]) ier <= ier | din[6:0];
        else        ier <= ier & ~din[6:0];
      end
    end
  end

`ifdef VIA_PB7_EN
  // PB7 square-wave flop: cleared on T1 load, toggles (free-run) or sets (one-shot) on fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pb7_flop <= 1'b0;
    else if (t1_load)  pb7_flop <= 1'b0;
    else if (t1_fire)  pb7_flop <= acr[6] ? ~pb7_flop : 1'b1;
  end
  assign pb7_active = acr[7];
`else
  assign pb7_flop   = 1'b0;
  assign pb7_active = 1'b0;
`endif

  assign irq    = |(ifr & ier);
  assign irq_n  = ~irq;
  assign pa_out = ora;
  assign pa_oe  = ddra;
  assign pb_out = pb7_active ? {pb7_flop, orb[6:0]} : orb;
  assign pb_oe  = pb7_active ? {1'b1, ddrb[6:0]} : ddrb;

  // Port B input view: driven bits read back the output register.
  always_comb begin
    irb = (orb & ddrb) | (pb_in & ~ddrb);
    if (pb7_active) irb[7] = pb7_flop;
  end

  // Combinational read multiplexor.
  always_comb begin
    dout = 8'h00;
    case (addr)
      4'h0:       dout = irb;
      4'h1, 4'hF: dout = pa_in;
      4'h2:       dout = ddrb;
      4'h3:       dout = ddra;
      4'h4:       dout = t1_cnt[7:0];
      4'h5:       dout = t1_cnt[15:8];
      4'h6:       dout = t1_latch[7:0];
      4'h7:       dout = t1_latch[15:8];
      4'h8:       dout = t2_cnt[7:0];
      4'h9:       dout = t2_cnt[15:8];
      4'hA:       dout = 8'h00;
      4'hB:       dout = acr;
      4'hC:       dout = pcr;
      4'hD:       dout = {irq, ifr};
      4'hE:       dout = {1'b1, ier};
      default:    dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_via6522.sv
// tb_via6522: directed scoreboard bench for via6522.
// Expected values are queued when stimulus is applied and popped when the
// corresponding DUT output is sampled (1 time unit after the active edge).
module tb_via6522;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cs, rnw;
  logic [3:0] addr;
  logic [7:0] din, dout, pa_in, pa_out, pa_oe, pb_in, pb_out, pb_oe;
  logic       irq_n;
  logic [7:0] rd_val;

  string      tag_q[$];
  logic [7:0] val_q[$];
  int         compared   = 0;
  int         mismatched = 0;

  via6522 dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .rnw(rnw), .addr(addr), .din(din),
    .dout(dout), .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe),
    .pb_in(pb_in), .pb_out(pb_out), .pb_oe(pb_oe), .irq_n(irq_n)
  );

  // 100 MHz-style bench clock; only edge counts matter to the design.
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectVal(input string tag, input logic [7:0] value);
    tag_q.push_back(tag);
    val_q.push_back(value);
  endtask

  task automatic checkOutput(input logic [7:0] observed);
    string      tag;
    logic [7:0] required;
    compared++;
    if (val_q.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty observed=%02h required=none", observed);
      return;
    end
    tag      = tag_q.pop_front();
    required = val_q.pop_front();
    assert (observed === required) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%02h required=%02h", tag, observed, required);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rnw = 1'b0; addr = a; din = d;
    @(posedge clk);
    #1;
    cs = 1'b0; rnw = 1'b1;
  endtask

  task automatic readReg(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rnw = 1'b1; addr = a;
    #1 d = dout;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic readCheck(input logic [3:0] a, input string tag, input logic [7:0] value);
    logic [7:0] v;
    expectVal(tag, value);
    readReg(a, v);
    checkOutput(v);
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIrq(input string tag, input logic value);
    expectVal(tag, {7'b0, value});
    checkOutput({7'b0, irq_n});
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; rnw = 1'b1; addr = 4'h0; din = 8'h00;
    pa_in = 8'h00; pb_in = 8'h00;
    #12;
    $display("[TB] reset values");
    checkIrq("reset_irq_n", 1'b1);
    expectVal("reset_pa_oe", 8'h00);  checkOutput(pa_oe);
    expectVal("reset_pb_oe", 8'h00);  checkOutput(pb_oe);
    expectVal("reset_pb_out", 8'h00); checkOutput(pb_out);
    @(negedge clk);
    reset_n = 1'b1;
    readCheck(4'hE, "reset_ier", 8'h80);
    readCheck(4'h5, "reset_t1_hi", 8'hFF);
    readCheck(4'hA, "sr_reads_zero", 8'h00);

    $display("[TB] ports");
    pb_in = 8'h3C; pa_in = 8'hC3;
    applyStimulus(4'h2, 8'h0F);
    applyStimulus(4'h0, 8'hA5);
    expectVal("pb_out", 8'hA5); checkOutput(pb_out);
    expectVal("pb_oe", 8'h0F);  checkOutput(pb_oe);
    readCheck(4'h0, "irb", 8'h35);
    applyStimulus(4'h3, 8'hF0);
    applyStimulus(4'h1, 8'h5A);
    expectVal("pa_out", 8'h5A); checkOutput(pa_out);
    expectVal("pa_oe", 8'hF0);  checkOutput(pa_oe);
    readCheck(4'h1, "ira", 8'hC3);
    readCheck(4'hF, "ira_nohs", 8'hC3);
    applyStimulus(4'hC, 8'h69);
    readCheck(4'hC, "pcr", 8'h69);

    $display("[TB] timer 1 one-shot");
    applyStimulus(4'hE, 8'hC0);
    applyStimulus(4'h4, 8'h05);
    applyStimulus(4'h5, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      stepEdge();
      checkIrq($sformatf("t1_os_irq_e%0d", k), (k == 6) ? 1'b0 : 1'b1);
    end
    readCheck(4'h4, "t1_wrapped_lo", 8'hFF);
    checkIrq("t1_read_clears", 1'b1);

    $display("[TB] timer 1 free-run");
    applyStimulus(4'hB, 8'h40);
    applyStimulus(4'h6, 8'h03);
    applyStimulus(4'h7, 8'h00);
    applyStimulus(4'h5, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      stepEdge();
      checkIrq($sformatf("t1_fr_irq_e%0d", k), (k == 4) ? 1'b0 : 1'b1);
    end
    applyStimulus(4'hD, 8'h40);
    checkIrq("t1_fr_ifr_cleared", 1'b1);
    for (int k = 6; k <= 9; k++) begin
      stepEdge();
      checkIrq($sformatf("t1_fr_irq_e%0d", k), (k == 9) ? 1'b0 : 1'b1);
    end
    applyStimulus(4'hB, 8'h00);
    repeat (12) stepEdge();
    applyStimulus(4'hD, 8'h7F);
    applyStimulus(4'hE, 8'h40);
    readCheck(4'hD, "ifr_all_clear", 8'h00);

    $display("[TB] timer 2");
    applyStimulus(4'hE, 8'hA0);
    applyStimulus(4'h8, 8'h02);
    applyStimulus(4'h9, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      stepEdge();
      checkIrq($sformatf("t2_irq_e%0d", k), (k == 3) ? 1'b0 : 1'b1);
    end
    readCheck(4'hD, "t2_ifr_set", 8'hA0);
    applyStimulus(4'hD, 8'h20);
    checkIrq("t2_ifr_cleared", 1'b1);
    repeat (65540) stepEdge();
    readCheck(4'hD, "t2_no_refire", 8'h00);
    applyStimulus(4'h9, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      stepEdge();
      checkIrq($sformatf("t2_rearm_irq_e%0d", k), (k == 3) ? 1'b0 : 1'b1);
    end
    applyStimulus(4'hE, 8'h20);
    checkIrq("ier_clear_irq", 1'b1);
    readCheck(4'hD, "ifr5_kept", 8'h20);
    readCheck(4'hE, "ier_after_clear", 8'h80);

    $display("[TB] PB7 behaviour");
    applyStimulus(4'h6, 8'h01);
    applyStimulus(4'h7, 8'h00);
    applyStimulus(4'hB, 8'hC0);
    applyStimulus(4'h5, 8'h00);
`ifdef VIA_PB7_EN
    expectVal("pb7_oe", 8'h8F); checkOutput(pb_oe);
    for (int k = 1; k <= 5; k++) begin
      stepEdge();
      expectVal($sformatf("pb7_out_e%0d", k), (k >= 2 && k <= 4) ? 8'hA5 : 8'h25);
      checkOutput(pb_out);
    end
`else
    expectVal("pb7_oe_plain", 8'h0F); checkOutput(pb_oe);
    for (int k = 1; k <= 5; k++) begin
      stepEdge();
      expectVal($sformatf("pb7_out_plain_e%0d", k), 8'hA5);
      checkOutput(pb_out);
    end
`endif

    $display("[TB] asynchronous reset");
    applyStimulus(4'hE, 8'hA0);
    checkIrq("pre_reset_irq", 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkIrq("async_reset_irq", 1'b1);
    expectVal("async_reset_pb_out", 8'h00); checkOutput(pb_out);
    expectVal("async_reset_pb_oe", 8'h00);  checkOutput(pb_oe);
    expectVal("async_reset_pa_out", 8'h00); checkOutput(pa_out);
    @(negedge clk);
    reset_n = 1'b1;
    readCheck(4'hD, "post_reset_ifr", 8'h00);
    readCheck(4'h5, "post_reset_t1_hi", 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
